// File: rtl/axi4_lite_bram_bridge_if.sv
// AXI4-Lite bus bundle between a CPU-side master and the BRAM bridge slave.
// A transfer occurs on a rising edge where valid and ready are both high; the source holds valid and payload stable until then, and ready may depend combinationally on valid.
interface axi4_lite_bram_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB-1:0]       s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi4_lite_bram_bridge.sv
// AXI4-Lite slave onto one single-port BRAM port: one outstanding access, fair read/write
// arbitration, SLVERR for word indices beyond the populated depth.
module axi4_lite_bram_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  axi4_lite_bram_bridge_if.slave    s_axi,
  output logic                      bram_en_a,
  output logic [DATA_WIDTH/8-1:0]   bram_we_a,
  output logic [ADDR_WIDTH-1:0]     bram_addr_a,
  output logic [DATA_WIDTH-1:0]     bram_wrdata_a,
  input  logic [DATA_WIDTH-1:0]     bram_rddata_a,
  output logic [2:0]                dbg_state
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int ALSB = $clog2(STRB);
  localparam int IW   = ADDR_WIDTH - ALSB;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic PRIO_WR = 1'b0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RWAIT = 3'd4,
    S_RRESP = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IW-1:0]         waddr_q, waddr_d;
  logic [IW-1:0]         raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB-1:0]       wstrb_q, wstrb_d;
  logic                  prio_q, prio_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            bresp_q, bresp_d;

  logic awready_c, wready_c, arready_c, bvalid_c, rvalid_c;
  logic aw_hs, w_hs, ar_hs, want_wr, w_ok, r_ok;
  logic en_c;
  logic [STRB-1:0]       we_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] wrdata_c;

  // Low address bits select bytes within a word and play no part in the access.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi.s_axi_awaddr[ALSB-1:0], s_axi.s_axi_araddr[ALSB-1:0]};

  assign w_ok = ({{(ALSB+1){1'b0}}, waddr_q} < DEPTH_W);
  assign r_ok = ({{(ALSB+1){1'b0}}, raddr_q} < DEPTH_W);

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    arready_c = 1'b0;
    bvalid_c  = 1'b0;
    rvalid_c  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    ar_hs     = 1'b0;
    en_c      = 1'b0;
    we_c      = '0;
    addr_c    = '0;
    wrdata_c  = '0;
    want_wr   = (aw_held_q | s_axi.s_axi_awvalid) & (w_held_q | s_axi.s_axi_wvalid);

    case (state_q)
      S_IDLE: begin
        // A read may only start when no write half is parked and writes don't hold priority.
        arready_c = !aw_held_q && !w_held_q && (!want_wr || (prio_q != PRIO_WR));
        ar_hs     = arready_c && s_axi.s_axi_arvalid;
        awready_c = !aw_held_q && !ar_hs;
        wready_c  = !w_held_q && !ar_hs;
        aw_hs     = awready_c && s_axi.s_axi_awvalid;
        w_hs      = wready_c && s_axi.s_axi_wvalid;
        if (aw_hs) begin
          aw_held_d = 1'b1;
          waddr_d   = s_axi.s_axi_awaddr[ADDR_WIDTH-1:ALSB];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.s_axi_wdata;
          wstrb_d  = s_axi.s_axi_wstrb;
        end
        if (ar_hs) begin
          raddr_d = s_axi.s_axi_araddr[ADDR_WIDTH-1:ALSB];
          prio_d  = !prio_q;
          state_d = S_RD;
        end else if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          prio_d    = !prio_q;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        if (w_ok) begin
          en_c     = 1'b1;
          we_c     = wstrb_q;
          addr_c   = {waddr_q, {ALSB{1'b0}}};
          wrdata_c = wdata_q;
        end
        bresp_d = w_ok ? RESP_OKAY : RESP_SLVERR;
        state_d = S_WRESP;
      end
      S_WRESP: begin
        bvalid_c = 1'b1;
        if (s_axi.s_axi_bready) state_d = S_IDLE;
      end
      S_RD: begin
        if (r_ok) begin
          en_c    = 1'b1;
          addr_c  = {raddr_q, {ALSB{1'b0}}};
          cnt_d   = 2'(RD_LATENCY - 1);
          state_d = S_RWAIT;
        end else begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          state_d = S_RRESP;
        end
      end
      S_RWAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = bram_rddata_a;
          rresp_d = RESP_OKAY;
          state_d = S_RRESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RRESP: begin
        rvalid_c = 1'b1;
        if (s_axi.s_axi_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (s_axi_areset) begin
      awready_c = 1'b0;
      wready_c  = 1'b0;
      arready_c = 1'b0;
      bvalid_c  = 1'b0;
      rvalid_c  = 1'b0;
      en_c      = 1'b0;
      we_c      = '0;
      addr_c    = '0;
      wrdata_c  = '0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q   <= S_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prio_q    <= PRIO_WR;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axi.s_axi_awready = awready_c;
  assign s_axi.s_axi_wready  = wready_c;
  assign s_axi.s_axi_arready = arready_c;
  assign s_axi.s_axi_bvalid  = bvalid_c;
  assign s_axi.s_axi_rvalid  = rvalid_c;
  assign s_axi.s_axi_bresp   = s_axi_areset ? 2'b00 : bresp_q;
  assign s_axi.s_axi_rresp   = s_axi_areset ? 2'b00 : rresp_q;
  assign s_axi.s_axi_rdata   = s_axi_areset ? '0 : rdata_q;
  assign bram_en_a           = en_c;
  assign bram_we_a           = we_c;
  assign bram_addr_a         = addr_c;
  assign bram_wrdata_a       = wrdata_c;
  assign dbg_state           = s_axi_areset ? 3'd0 : state_q;
endmodule

// File: tb/tb_axi4_lite_bram_bridge.sv
// Directed bench for axi4_lite_bram_bridge with RD_LATENCY=2 and 512 populated words.
module tb_axi4_lite_bram_bridge;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic            bram_en_a;
  logic [3:0]      bram_we_a;
  logic [AW-1:0]   bram_addr_a;
  logic [DW-1:0]   bram_wrdata_a;
  logic [DW-1:0]   bram_rddata_a;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt = 0;
  int b_cnt = 0;
  int overlap_cnt = 0;
  logic prev_en = 1'b0;
  logic sb_on = 1'b0;
  logic [0:0] exp_q[$];

  axi4_lite_bram_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_bram_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .MEM_DEPTH(512)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(axi),
    .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // BRAM model with two-clock read latency
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rd_p0, rd_p1;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bram_en_a) begin
      rd_p0 <= mem[bram_addr_a[11:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we_a[b]) mem[bram_addr_a[11:2]][b*8 +: 8] <= bram_wrdata_a[b*8 +: 8];
    end
    rd_p1 <= rd_p0;
  end
  assign bram_rddata_a = rd_p1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard of grant order, sampled mid-cycle
  always @(negedge clk) begin
    #2;
    if (bram_en_a) begin
      en_cnt++;
      if (prev_en) overlap_cnt++;
      if (sb_on && exp_q.size() > 0) check_eq("arb_grant", 64'(bram_we_a != 4'h0), 64'(exp_q.pop_front()));
    end
    prev_en = bram_en_a;
    if (axi.s_axi_bvalid && axi.s_axi_bready) b_cnt++;
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int t;
    axi.s_axi_awaddr = a; axi.s_axi_wdata = d; axi.s_axi_wstrb = s;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    t = 0; #1;
    while (!(axi.s_axi_awready && axi.s_axi_wready) && t < 50) begin @(negedge clk); #1; t++; end
    check_eq("aw_w_accept", 64'(axi.s_axi_awready && axi.s_axi_wready), 64'd1);
    @(negedge clk);
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    t = 0; #1;
    while (!axi.s_axi_bvalid && t < 50) begin @(negedge clk); #1; t++; end
    check_eq("b_arrive", 64'(axi.s_axi_bvalid), 64'd1);
    resp = axi.s_axi_bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    int t;
    axi.s_axi_araddr = a; axi.s_axi_arvalid = 1'b1;
    t = 0; #1;
    while (!axi.s_axi_arready && t < 50) begin @(negedge clk); #1; t++; end
    check_eq("ar_accept", 64'(axi.s_axi_arready), 64'd1);
    @(negedge clk);
    axi.s_axi_arvalid = 1'b0;
    t = 0; #1;
    while (!axi.s_axi_rvalid && t < 50) begin @(negedge clk); #1; t++; end
    check_eq("r_arrive", 64'(axi.s_axi_rvalid), 64'd1);
    d = axi.s_axi_rdata; resp = axi.s_axi_rresp;
    @(negedge clk);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  int en0, b0, seen;

  initial begin
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b1; axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b1;

    // reset: outputs quiet, then idle and ready
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_quiet", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready,
                           axi.s_axi_bvalid, axi.s_axi_rvalid, bram_en_a}, 0);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("idle_ready", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 3'b111);
    check_eq("rst_dbg_state", dbg_state, 3'd0);

    // cycle-accurate write of 0xDEADBEEF to 0x004
    @(negedge clk);
    axi.s_axi_awaddr = 12'h004; axi.s_axi_wdata = 32'hDEADBEEF; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    @(negedge clk); axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; #1;
    check_eq("wr_issue", {bram_en_a, bram_we_a, bram_addr_a, bram_wrdata_a}, {1'b1, 4'hF, 12'h004, 32'hDEADBEEF});
    @(negedge clk); #1;
    check_eq("wr_bresp", {bram_en_a, bram_we_a, axi.s_axi_bvalid, axi.s_axi_bresp}, {1'b0, 4'h0, 1'b1, 2'b00});
    @(negedge clk);

    // cycle-accurate read of 0x004: rvalid four cycles after AR
    axi.s_axi_araddr = 12'h006; axi.s_axi_arvalid = 1'b1; #1;
    check_eq("ar_ready", axi.s_axi_arready, 1'b1);
    @(negedge clk); axi.s_axi_arvalid = 1'b0; #1;
    check_eq("rd_issue", {bram_en_a, bram_we_a, bram_addr_a}, {1'b1, 4'h0, 12'h004});
    @(negedge clk); #1; check_eq("rd_wait1", {bram_en_a, axi.s_axi_rvalid}, 2'b00);
    @(negedge clk); #1; check_eq("rd_wait2", {bram_en_a, axi.s_axi_rvalid}, 2'b00);
    @(negedge clk); #1;
    check_eq("rd_data", {axi.s_axi_rvalid, axi.s_axi_rresp, axi.s_axi_rdata}, {1'b1, 2'b00, 32'hDEADBEEF});
    @(negedge clk);

    // W three cycles before AW: held, then exactly one write and one response
    en0 = en_cnt; b0 = b_cnt;
    axi.s_axi_wdata = 32'hA5A50001; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1; #1;
    check_eq("w_early_ready", axi.s_axi_wready, 1'b1);
    @(negedge clk); axi.s_axi_wvalid = 1'b0; #1;
    check_eq("w_held", {axi.s_axi_wready, axi.s_axi_awready, axi.s_axi_arready}, 3'b010);
    repeat (2) @(negedge clk);
    axi.s_axi_awaddr = 12'h020; axi.s_axi_awvalid = 1'b1; #1;
    check_eq("aw_late_ready", axi.s_axi_awready, 1'b1);
    @(negedge clk); axi.s_axi_awvalid = 1'b0; #1;
    check_eq("w_late_issue", {bram_en_a, bram_addr_a, bram_wrdata_a}, {1'b1, 12'h020, 32'hA5A50001});
    repeat (3) @(negedge clk);
    check_eq("w_late_one_en", en_cnt - en0, 1);
    check_eq("w_late_one_b", b_cnt - b0, 1);
    axi_read(12'h020, rd, resp);
    check_eq("w_late_readback", rd, 32'hA5A50001);

    // partial strobes
    axi_write(12'h010, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(12'h010, 32'h12345678, 4'h3, resp);
    check_eq("strb_bresp", resp, 2'b00);
    axi_read(12'h010, rd, resp);
    check_eq("strb_merge", rd, 32'hFFFF5678);

    // zero strobe still completes OKAY and changes nothing
    axi_write(12'h004, 32'h00000000, 4'h0, resp);
    check_eq("strb0_bresp", resp, 2'b00);
    axi_read(12'h004, rd, resp);
    check_eq("strb0_keep", rd, 32'hDEADBEEF);

    // last populated word
    axi_write(12'h7FC, 32'hCAFEF00D, 4'hF, resp);
    check_eq("top_bresp", resp, 2'b00);
    axi_read(12'h7FC, rd, resp);
    check_eq("top_read", {resp, rd}, {2'b00, 32'hCAFEF00D});

    // out of range: SLVERR at N+2, no enable
    en0 = en_cnt;
    axi.s_axi_awaddr = 12'h800; axi.s_axi_wdata = 32'h11111111; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    @(negedge clk); axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; #1;
    check_eq("oor_wr_noen", bram_en_a, 1'b0);
    @(negedge clk); #1;
    check_eq("oor_bresp", {axi.s_axi_bvalid, axi.s_axi_bresp}, 3'b110);
    @(negedge clk);
    axi.s_axi_araddr = 12'h803; axi.s_axi_arvalid = 1'b1;
    @(negedge clk); axi.s_axi_arvalid = 1'b0; #1;
    check_eq("oor_rd_noen", bram_en_a, 1'b0);
    @(negedge clk); #1;
    check_eq("oor_rresp", {axi.s_axi_rvalid, axi.s_axi_rresp, axi.s_axi_rdata}, {1'b1, 2'b10, 32'h0});
    @(negedge clk);
    check_eq("oor_en_count", en_cnt - en0, 0);

    // bready held low: response and readies frozen
    axi.s_axi_bready = 1'b0;
    axi.s_axi_awaddr = 12'h030; axi.s_axi_wdata = 32'h0BADF00D; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    @(negedge clk); axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("b_hold", {axi.s_axi_bvalid, axi.s_axi_bresp, axi.s_axi_awready, axi.s_axi_arready}, 5'b10000);
      @(negedge clk);
    end
    axi.s_axi_bready = 1'b1;
    @(negedge clk); #1;
    check_eq("b_release", {axi.s_axi_bvalid, axi.s_axi_awready}, 2'b01);
    @(negedge clk);

    // reset during the read wait drops the read
    axi.s_axi_araddr = 12'h004; axi.s_axi_arvalid = 1'b1;
    @(negedge clk); axi.s_axi_arvalid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rst_mid_quiet", {axi.s_axi_arready, axi.s_axi_rvalid, bram_en_a, axi.s_axi_rdata}, 0);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rst_mid_idle", {axi.s_axi_rvalid, bram_en_a, axi.s_axi_awready}, 3'b001);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (axi.s_axi_rvalid) seen++;
    end
    check_eq("rst_mid_no_rvalid", seen, 0);
    @(negedge clk);

    // contested arbitration from reset: W,R,W,R
    rst = 1'b1;
    axi.s_axi_awaddr = 12'h040; axi.s_axi_wdata = 32'h55AA55AA; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_araddr = 12'h040;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_arvalid = 1'b1;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    overlap_cnt = 0;
    sb_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    while (exp_q.size() > 0 && seen < 80) begin @(negedge clk); seen++; end
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
    check_eq("arb_all_granted", exp_q.size(), 0);
    sb_on = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("arb_no_overlap", overlap_cnt, 0);
    axi_read(12'h010, rd, resp);
    check_eq("final_read", {resp, rd}, {2'b00, 32'hFFFF5678});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
